// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes understood by the execute stage and the
// state encoding of its sequencer. ALU_Control imports the same package so both
// ends of the 3-bit code always agree.
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_MUL  = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b101;
    localparam logic [2:0] ALU_SRAI = 3'b110;
    localparam logic [2:0] ALU_LS   = 3'b111;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_seq_exec_if.sv
// Request/response bundle between the issue logic and the execute-stage ALU.
interface alu_seq_exec_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) ();
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [TAG_W-1:0] rd_i;
    logic             kill_i;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic [TAG_W-1:0] rd_o;
    logic             stall_o;

    modport master (
        output valid_i, ALUCtrl_i, data1_i, data2_i, rd_i, kill_i,
        input  ready_o, valid_o, result_o, zero_o, rd_o, stall_o
    );

    modport slave (
        input  valid_i, ALUCtrl_i, data1_i, data2_i, rd_i, kill_i,
        output ready_o, valid_o, result_o, zero_o, rd_o, stall_o
    );
endinterface

// File: rtl/alu_seq_exec_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH steps.
// done_o is high during the last step; product_o then already includes it.
module mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             run_i,
    input  logic             kill_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_step_s;

    assign acc_step_s = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
    assign product_o  = acc_step_s;
    assign done_o     = run_i & ~kill_i & (cnt_q == CNT_LAST);

    // Load on start, abandon on kill, otherwise take one shift-add step per cycle.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            acc_d    = {WIDTH{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
        end else if (kill_i) begin
            acc_d    = {WIDTH{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
        end else if (run_i) begin
            acc_d    = acc_step_s;
            mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + CNT_ONE;
        end else begin
            cnt_d    = cnt_q;
        end
    end

    // Engine registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU. Single-cycle ops return a registered result one cycle after
// acceptance; MUL is handed to mul_iter and the block stays busy (ready low)
// until the product is written into the output registers.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    alu_seq_exec_if.slave bus
);

    alu_state_e       state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [TAG_W-1:0] rd_q, rd_d;
    logic [TAG_W-1:0] mul_rd_q, mul_rd_d;

    logic [WIDTH-1:0]   alu_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic               accept_s;
    logic               mul_start_s;
    logic               mul_run_s;
    logic               mul_done_s;
    logic [WIDTH-1:0]   mul_product_s;

    assign shamt_s   = bus.data2_i[SHAMT_W-1:0];
    assign accept_s  = bus.valid_i & ~bus.kill_i & (state_q == IDLE);
    assign mul_run_s = (state_q == MUL_RUN);

    mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start_s),
        .run_i     (mul_run_s),
        .kill_i    (bus.kill_i),
        .mcand_i   (bus.data1_i),
        .mplier_i  (bus.data2_i),
        .done_o    (mul_done_s),
        .product_o (mul_product_s)
    );

    // Single-cycle datapath; MUL results come from the iterative engine instead.
    always_comb begin
        alu_s = {WIDTH{1'b0}};
        case (bus.ALUCtrl_i)
            ALU_ADD,
            ALU_LS:   alu_s = bus.data1_i + bus.data2_i;
            ALU_SUB:  alu_s = bus.data1_i - bus.data2_i;
            ALU_AND:  alu_s = bus.data1_i & bus.data2_i;
            ALU_XOR:  alu_s = bus.data1_i ^ bus.data2_i;
            ALU_SLL:  alu_s = bus.data1_i << shamt_s;
            ALU_SRAI: alu_s = $signed(bus.data1_i) >>> shamt_s;
            ALU_MUL:  alu_s = {WIDTH{1'b0}};
            default:  alu_s = {WIDTH{1'b0}};
        endcase
    end

    // Sequencer: next state, MUL launch and output-register updates.
    always_comb begin
        state_d     = state_q;
        valid_d     = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        rd_d        = rd_q;
        mul_rd_d    = mul_rd_q;
        mul_start_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (bus.ALUCtrl_i == ALU_MUL) begin
                        mul_start_s = 1'b1;
                        mul_rd_d    = bus.rd_i;
                        state_d     = MUL_RUN;
                    end else begin
                        valid_d  = 1'b1;
                        result_d = alu_s;
                        zero_d   = (alu_s == {WIDTH{1'b0}});
                        rd_d     = bus.rd_i;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MUL_RUN: begin
                if (bus.kill_i) begin
                    state_d = IDLE;
                end else if (mul_done_s) begin
                    state_d  = IDLE;
                    valid_d  = 1'b1;
                    result_d = mul_product_s;
                    zero_d   = (mul_product_s == {WIDTH{1'b0}});
                    rd_d     = mul_rd_q;
                end else begin
                    state_d = MUL_RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; an asynchronous reset discards any MUL in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            zero_q   <= 1'b0;
            rd_q     <= {TAG_W{1'b0}};
            mul_rd_q <= {TAG_W{1'b0}};
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            rd_q     <= rd_d;
            mul_rd_q <= mul_rd_d;
        end
    end

    assign bus.ready_o  = (state_q == IDLE);
    assign bus.stall_o  = (state_q != IDLE);
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;
    assign bus.zero_o   = zero_q;
    assign bus.rd_o     = rd_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec: a table of single-cycle ops issued
// back-to-back, then hand-written MUL, kill and reset sequences.
module tb_alu_seq_exec;
    import alu_pkg::*;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int TAG_W   = 5;
    localparam int NVEC    = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_seq_exec_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    alu_seq_exec #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W),
        .TAG_W   (TAG_W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic [2:0] ctrl, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd);
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = ctrl;
        bus.data1_i   = a;
        bus.data2_i   = b;
        bus.rd_i      = rd;
    endtask

    // Called at a negedge. Issues a MUL, optionally keeps an ADD 1+1 (rd 4)
    // requested while busy, and checks busy length, result and follow-up.
    task automatic mul_seq(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] exp, input logic exp_zero, input bit follow_add);
        int busy;
        bit got;
        busy = 0;
        got  = 1'b0;
        drive_op(ALU_MUL, a, b, rd);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (follow_add) drive_op(ALU_ADD, 32'd1, 32'd1, 5'd4);
                else            bus.valid_i = 1'b0;
            end
            if (bus.valid_o) got = 1'b1;
            else if (!bus.ready_o) busy++;
        end
        check("mul done seen", {31'b0, got}, 32'd1);
        check("mul busy cycles", busy, 32'd32);
        check("mul result", bus.result_o, exp);
        check("mul zero", {31'b0, bus.zero_o}, {31'b0, exp_zero});
        check("mul rd", {27'b0, bus.rd_o}, {27'b0, rd});
        check("mul ready after", {31'b0, bus.ready_o}, 32'd1);
        check("mul stall after", {31'b0, bus.stall_o}, 32'd0);
        @(negedge clk);
        if (follow_add) begin
            bus.valid_i = 1'b0;
            check("held add valid", {31'b0, bus.valid_o}, 32'd1);
            check("held add result", bus.result_o, 32'd2);
            check("held add rd", {27'b0, bus.rd_o}, 32'd4);
            @(negedge clk);
        end
        check("valid pulse ends", {31'b0, bus.valid_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] prev;
        bit          seen;

        vecs[0]  = '{ALU_ADD,  32'd5,        32'd7,        5'd3,  32'd12,       1'b0};
        vecs[1]  = '{ALU_SUB,  32'd9,        32'd9,        5'd4,  32'd0,        1'b1};
        vecs[2]  = '{ALU_SRAI, 32'h80000000, 32'd4,        5'd5,  32'hF8000000, 1'b0};
        vecs[3]  = '{ALU_SLL,  32'd1,        32'd31,       5'd6,  32'h80000000, 1'b0};
        vecs[4]  = '{ALU_XOR,  32'hFF00FF00, 32'h0F0F0F0F, 5'd7,  32'hF00FF00F, 1'b0};
        vecs[5]  = '{ALU_AND,  32'h0000F0F0, 32'h0000FF00, 5'd8,  32'h0000F000, 1'b0};
        vecs[6]  = '{ALU_LS,   32'h00001000, 32'h00000024, 5'd9,  32'h00001024, 1'b0};
        vecs[7]  = '{ALU_ADD,  32'hFFFFFFFF, 32'd1,        5'd10, 32'd0,        1'b1};
        vecs[8]  = '{ALU_SRAI, 32'h7FFFFFF0, 32'd4,        5'd11, 32'h07FFFFFF, 1'b0};
        vecs[9]  = '{ALU_SLL,  32'd3,        32'hFFFFFFE1, 5'd12, 32'd6,        1'b0};
        vecs[10] = '{ALU_SUB,  32'd0,        32'd1,        5'd13, 32'hFFFFFFFF, 1'b0};

        bus.valid_i   = 1'b0;
        bus.kill_i    = 1'b0;
        bus.ALUCtrl_i = 3'b000;
        bus.data1_i   = 32'd0;
        bus.data2_i   = 32'd0;
        bus.rd_i      = 5'd0;

        // Reset state
        #2;
        check("reset ready", {31'b0, bus.ready_o}, 32'd1);
        check("reset stall", {31'b0, bus.stall_o}, 32'd0);
        check("reset valid", {31'b0, bus.valid_o}, 32'd0);
        check("reset result", bus.result_o, 32'd0);
        check("reset zero", {31'b0, bus.zero_o}, 32'd0);
        check("reset rd", {27'b0, bus.rd_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back single-cycle ops
        for (int i = 0; i < NVEC; i++) begin
            drive_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].rd);
            @(negedge clk);
            check($sformatf("vec%0d valid", i), {31'b0, bus.valid_o}, 32'd1);
            check($sformatf("vec%0d result", i), bus.result_o, vecs[i].res);
            check($sformatf("vec%0d zero", i), {31'b0, bus.zero_o}, {31'b0, vecs[i].zero});
            check($sformatf("vec%0d rd", i), {27'b0, bus.rd_o}, {27'b0, vecs[i].rd});
            check($sformatf("vec%0d ready", i), {31'b0, bus.ready_o}, 32'd1);
        end
        bus.valid_i = 1'b0;
        @(negedge clk);
        check("valid after table", {31'b0, bus.valid_o}, 32'd0);
        check("result holds", bus.result_o, 32'hFFFFFFFF);

        // Multiplies
        mul_seq(32'd7, 32'd6, 5'd9, 32'd42, 1'b0, 1'b0);
        mul_seq(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'd1, 1'b0, 1'b0);
        mul_seq(32'd3, 32'd5, 5'd11, 32'd15, 1'b0, 1'b1);
        mul_seq(32'd0, 32'h00001234, 5'd12, 32'd0, 1'b1, 1'b0);

        // Kill in the middle of a MUL
        prev = bus.result_o;
        drive_op(ALU_MUL, 32'h00001234, 32'h00000010, 5'd7);
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (9) @(negedge clk);
        bus.kill_i = 1'b1;
        @(negedge clk);
        bus.kill_i = 1'b0;
        check("kill valid", {31'b0, bus.valid_o}, 32'd0);
        check("kill ready", {31'b0, bus.ready_o}, 32'd1);
        check("kill result held", bus.result_o, prev);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.valid_o) seen = 1'b1;
        end
        check("no pulse after kill", {31'b0, seen}, 32'd0);
        drive_op(ALU_AND, 32'h0000F0F0, 32'h0000FF00, 5'd2);
        @(negedge clk);
        bus.valid_i = 1'b0;
        check("and after kill valid", {31'b0, bus.valid_o}, 32'd1);
        check("and after kill result", bus.result_o, 32'h0000F000);
        check("and after kill rd", {27'b0, bus.rd_o}, 32'd2);

        // Kill beats a request in IDLE
        drive_op(ALU_ADD, 32'd5, 32'd5, 5'd1);
        bus.kill_i = 1'b1;
        @(negedge clk);
        bus.kill_i  = 1'b0;
        bus.valid_i = 1'b0;
        check("idle kill valid", {31'b0, bus.valid_o}, 32'd0);
        check("idle kill result", bus.result_o, 32'h0000F000);
        check("idle kill rd", {27'b0, bus.rd_o}, 32'd2);

        // Asynchronous reset in the middle of a MUL
        drive_op(ALU_MUL, 32'd3, 32'd3, 5'd6);
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (14) @(negedge clk);
        check("busy before reset", {31'b0, bus.ready_o}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset valid", {31'b0, bus.valid_o}, 32'd0);
        check("mid reset result", bus.result_o, 32'd0);
        check("mid reset rd", {27'b0, bus.rd_o}, 32'd0);
        check("mid reset ready", {31'b0, bus.ready_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.valid_o) seen = 1'b1;
        end
        check("no pulse after reset", {31'b0, seen}, 32'd0);
        drive_op(ALU_ADD, 32'd2, 32'd2, 5'd1);
        @(negedge clk);
        bus.valid_i = 1'b0;
        check("add after reset valid", {31'b0, bus.valid_o}, 32'd1);
        check("add after reset result", bus.result_o, 32'd4);
        check("add after reset rd", {27'b0, bus.rd_o}, 32'd1);
        @(negedge clk);
        check("add after reset pulse ends", {31'b0, bus.valid_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Execute-stage ALU that consumes the 3-bit ALU control code produced by ALU_Control, together with two operands and a destination tag.
- Single-cycle ops return a registered result one cycle after acceptance.
- MUL runs on an iterative shift-add engine for WIDTH cycles. During that time the block exerts back-pressure, so the hazard logic can stall the pipeline.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount bits taken from data2_i[SHAMT_W-1:0]; must equal log2(WIDTH).
- TAG_W, 5, destination-register tag width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- valid_i  input  1  operation request.
- ready_o  output  1  block can accept; equals (state==IDLE).
- ALUCtrl_i  input  3  ALU control code.
- data1_i  input  WIDTH  operand A.
- data2_i  input  WIDTH  operand B or immediate.
- rd_i  input  TAG_W  destination tag.
- kill_i  input  1  flush; aborts the current or requested op.
- valid_o  output  1  one-cycle pulse, result valid.
- result_o  output  WIDTH  registered result.
- zero_o  output  1  registered, (result==0).
- rd_o  output  TAG_W  tag of the op being returned.
- stall_o  output  1  equals ~ready_o, for the hazard unit.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE.
  - valid_o=0, result_o=0, zero_o=0, rd_o=0.
  - Multiplier counter, accumulator and operand registers cleared.
  - ready_o=1, stall_o=0.
  - Reset asserted mid-MUL discards the op; no valid_o follows.
- Acceptance: rising edge with valid_i=1, ready_o=1, kill_i=0. valid_i while ready_o=0 is ignored (not consumed); upstream holds its request.
- Codes, arithmetic modulo 2^WIDTH:
  - 000 ADD, 001 SUB, 010 AND, 011 XOR.
  - 100 MUL, low WIDTH bits of the product; signedness is irrelevant.
  - 101 SLL, logical shift by data2_i[SHAMT_W-1:0].
  - 110 SRAI, arithmetic shift right by the same amount.
  - 111 ADD, load/store address.
- Single-cycle ops:
  - result_o, zero_o and rd_o are updated on the accepting edge; valid_o=1 for the following cycle (latency 1).
  - ready_o stays 1, so back-to-back ops are accepted every cycle.
- MUL state machine, states IDLE and MUL_RUN:
  - Accept edge E0: latch multiplicand=data1_i, multiplier=data2_i, acc=0, cnt=0, rd; go to MUL_RUN.
  - Each edge in MUL_RUN: if multiplier[0], acc+=multiplicand; multiplicand<<=1; multiplier>>=1; cnt++.
  - On the edge where cnt==WIDTH-1 (edge E_WIDTH):
    - result_o=final acc, zero_o updated, rd_o=latched tag.
    - valid_o=1 for the following cycle.
    - state goes to IDLE.
  - Result is visible WIDTH+1 cycles after acceptance. ready_o=0 for exactly WIDTH cycles.
- valid_o defaults to 0 on every edge that produces no result. result_o, zero_o and rd_o hold their last values between pulses.
- kill_i:
  - In MUL_RUN: go to IDLE on the next edge, no valid_o, result_o unchanged.
  - In IDLE with valid_i=1: kill wins; nothing is accepted and valid_o=0 next cycle.
- Simultaneous events: an op presented on the cycle the MUL completes is not accepted. ready_o is still 0 that cycle; it is accepted the next cycle.

Decomposition:
- Shared package alu_pkg:
  - ALU code constants ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_XOR=011, ALU_MUL=100, ALU_SLL=101, ALU_SRAI=110, ALU_LS=111.
  - State encoding IDLE/MUL_RUN.
  - Shared with ALU_Control so that both ends of the code stay in sync.
- One sub-module, mul_iter:
  - Shift-add engine with start/kill/done and a WIDTH-cycle counter.
  - alu_seq_exec holds the FSM, single-cycle datapath and output registers.

Test Plan:
1. ADD 5+7, rd=3 -> next cycle valid_o=1, result_o=12, zero_o=0, rd_o=3; valid_o=0 the cycle after.
2. Back-to-back ops on consecutive cycles, each with a 1-cycle result:
   - SUB 9-9 -> 0, zero_o=1.
   - SRAI 0x80000000 by 4 -> 0xF8000000.
   - SLL 1 by 31 -> 0x80000000.
   - XOR 0xFF00FF00^0x0F0F0F0F -> 0xF00FF00F.
3. MUL 7*6 -> ready_o=0 for 32 cycles; valid_o at cycle 33 with result 42. Then MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
4. ADD 1+1 presented with valid_i held during a busy MUL -> not accepted until ready_o=1. MUL result is returned first, then 2 one cycle after acceptance.
5. kill_i at cycle 10 of a MUL -> no valid_o, ready_o=1 next cycle. A following AND 0xF0F0 & 0xFF00 -> 0xF000.
6. rst_i low at cycle 15 of a MUL -> valid_o, result_o and rd_o go to 0 immediately and ready_o=1. After release, ADD 2+2 -> 4 with 1-cycle latency.
